// File: rtl/row_rotate_engine_pkg.sv
// Shared types and default geometry for the row-rotate engine.
// The FSM encoding lives here so the engine and any wrapper agree on it.
package row_rotate_engine_pkg;

   localparam int N_ROWS_DEF  = 4;
   localparam int ROW_W_DEF   = 4;
   localparam int ROUND_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } rre_state_t;

endpackage

// File: rtl/row_rotate_pass.sv
// One combinational pass: row r is rotated by (r mod ROW_W) bits,
// left when encrypt is high, right otherwise. Row 0 passes straight through.
module row_rotate_pass
   import row_rotate_engine_pkg::*;
#(
   parameter int N_ROWS = N_ROWS_DEF,
   parameter int ROW_W  = ROW_W_DEF
) (
   input  logic [N_ROWS*ROW_W-1:0] data,
   input  logic                    encrypt,
   output logic [N_ROWS*ROW_W-1:0] result
);

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      localparam int AMT = r % ROW_W;
      for (genvar b = 0; b < ROW_W; b++) begin : g_bit
         // Left rotate pulls from (b - AMT), right rotate from (b + AMT), both mod ROW_W.
         localparam int SRC_L = (b + ROW_W - AMT) % ROW_W;
         localparam int SRC_R = (b + AMT) % ROW_W;
         assign result[r*ROW_W + b] = encrypt ? data[r*ROW_W + SRC_L]
                                              : data[r*ROW_W + SRC_R];
      end
   end

endmodule

// File: rtl/row_rotate_engine.sv
// Multi-round row-rotate engine with valid/ready handshakes on both sides.
// A request is captured in IDLE, rotated once per BUSY cycle, and held in DONE.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | one pass per cycle until the round counter reaches terminal count
// DONE  | result held on out_data until out_ready
module row_rotate_engine
   import row_rotate_engine_pkg::*;
#(
   parameter int N_ROWS  = N_ROWS_DEF,
   parameter int ROW_W   = ROW_W_DEF,
   parameter int ROUND_W = ROUND_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_ROWS*ROW_W-1:0] in_data,
   input  logic                    in_encrypt,
   input  logic [ROUND_W-1:0]      in_rounds,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_ROWS*ROW_W-1:0] out_data,
   output logic                    busy
);

   localparam int WIDTH = N_ROWS * ROW_W;

   rre_state_t         state;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   pass_result;
   logic [ROUND_W-1:0] round_cnt;
   logic               mode;

   row_rotate_pass #(
      .N_ROWS (N_ROWS),
      .ROW_W  (ROW_W)
   ) u_pass (
      .data    (work),
      .encrypt (mode),
      .result  (pass_result)
   );

   // Every request spends at least one BUSY cycle; a zero round count simply
   // hits terminal count immediately and leaves the captured word untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         work      <= '0;
         round_cnt <= '0;
         mode      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  work      <= in_data;
                  mode      <= in_encrypt;
                  round_cnt <= in_rounds;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (round_cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  work      <= pass_result;
                  round_cnt <= round_cnt - ROUND_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_BUSY);
   assign out_valid = (state == ST_DONE);
   assign out_data  = work;

endmodule

// File: tb/tb_row_rotate_engine.sv
// Bench for row_rotate_engine: table-driven requests checked through a
// scoreboard, plus hand-written backpressure and reset-abort sequences.
module tb_row_rotate_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_encrypt;
   logic [3:0]  in_rounds;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      int          lat;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [15:0] d;
      logic        enc;
      logic [3:0]  r;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[8];

   row_rotate_engine #(
      .N_ROWS  (4),
      .ROW_W   (4),
      .ROUND_W (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_encrypt (in_encrypt),
      .in_rounds  (in_rounds),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference: each bit of row `row` moves to its rotated destination.
   function automatic logic [15:0] model(input logic [15:0] d, input logic enc, input int r);
      logic [15:0] cur;
      logic [15:0] nxt;
      int          a;
      int          dst;
      cur = d;
      for (int k = 0; k < r; k++) begin
         nxt = '0;
         for (int row = 0; row < 4; row++) begin
            a = row % 4;
            for (int b = 0; b < 4; b++) begin
               dst = enc ? (b + a) % 4 : (b + 4 - a) % 4;
               nxt[row*4 + dst] = cur[row*4 + b];
            end
         end
         cur = nxt;
      end
      return cur;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for out_valid, pops the scoreboard and compares data and latency.
   task automatic collect(input string name);
      int  lat;
      sb_t e;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      if (sb_q.size() == 0) begin
         chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_data"}, 32'(out_data), 32'(e.data));
         chk({name, "_lat"}, 32'(lat), 32'(e.lat));
      end
   endtask

   // Drives one request; after this returns the acceptance edge has just passed.
   task automatic issue(input logic [15:0] d, input logic enc, input logic [3:0] r,
                        input logic [15:0] exp);
      sb_t e;
      chk("in_ready_before_req", 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      in_data    = d;
      in_encrypt = enc;
      in_rounds  = r;
      e.data = exp;
      e.lat  = int'(r) + 1;
      sb_q.push_back(e);
      tick();
      in_valid   = 1'b0;
      in_data    = ~d;
      in_encrypt = ~enc;
      in_rounds  = ~r;
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, "_idle_ready"}, 32'(in_ready), 32'd1);
      chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] held;
      int          seen;

      vecs[0] = '{16'h1234, 1'b1, 4'd1,  16'h8864};
      vecs[1] = '{16'h8864, 1'b0, 4'd1,  16'h1234};
      vecs[2] = '{16'h1234, 1'b1, 4'd2,  16'h42C4};
      vecs[3] = '{16'h1234, 1'b1, 4'd0,  16'h1234};
      vecs[4] = '{16'h1234, 1'b1, 4'd4,  16'h1234};
      vecs[5] = '{16'hA5C3, 1'b0, 4'd3,  model(16'hA5C3, 1'b0, 3)};
      vecs[6] = '{16'h0E71, 1'b1, 4'd15, model(16'h0E71, 1'b1, 15)};
      vecs[7] = '{16'hBEEF, 1'b0, 4'd7,  model(16'hBEEF, 1'b0, 7)};

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = 16'hFFFF;
      in_encrypt = 1'b1;
      in_rounds  = 4'hF;
      out_ready  = 1'b0;
      repeat (3) tick();
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].d, vecs[i].enc, vecs[i].r, vecs[i].exp);
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
         collect($sformatf("vec%0d", i));
         release_result($sformatf("vec%0d", i));
      end

      // Backpressure: result held for 10 cycles while a second request is offered.
      issue(16'h1234, 1'b1, 4'd1, 16'h8864);
      collect("bp");
      held       = out_data;
      in_valid   = 1'b1;
      in_data    = 16'hFFFF;
      in_encrypt = 1'b0;
      in_rounds  = 4'd3;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("bp_hold_data_%0d", c), 32'(out_data), 32'h8864);
         chk($sformatf("bp_hold_ready_%0d", c), 32'(in_ready), 32'd0);
         chk($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      release_result("bp");
      chk("bp_not_busy", 32'(busy), 32'd0);
      tick();
      chk("bp_ignored_req_data", 32'(out_data), 32'(held));
      chk("bp_ignored_req_idle", 32'(in_ready), 32'd1);

      // Reset abort in the second BUSY cycle of a 5-round request.
      issue(16'hA5C3, 1'b1, 4'd5, 16'h0000);
      chk("abort_busy1", 32'(busy), 32'd1);
      tick();
      chk("abort_busy2", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_out_data", 32'(out_data), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      #1;
      rst = 1'b0;
      void'(sb_q.pop_back());
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      issue(16'h1234, 1'b1, 4'd2, 16'h42C4);
      collect("after_abort");
      release_result("after_abort");

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
